instr_decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage for the toy CPU. It accepts a stream of instruction words from fetch and decodes the top 4-bit opcode and low 4-bit subfield into a 27-bit one-hot control vector. For opcodes flagged as carrying an immediate, it collects a parametrised number of trailing immediate words. It then presents one complete decoded instruction per transaction to the execute stage.

---
 rtl/decode_pkg.sv | 18 +
 rtl/instr_decode_stage_if.sv | 30 +++
 rtl/decode_map.sv | 40 ++++
 rtl/instr_decode_stage.sv | 90 +++++++++
 tb/tb_instr_decode_stage.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared constants and types for the instruction decode stage: one-hot slot layout,
// FSM state encoding and the default immediate-bearing opcode mask.
package decode_pkg;

  localparam int unsigned NDEC      = 27;
  localparam int unsigned SLOT_OP0  = 0;
  localparam int unsigned SLOT_OP1  = 1;
  localparam int unsigned SLOT_ALU  = 5;
  localparam int unsigned SLOT_OP12 = 15;
  localparam int unsigned SLOT_OP13 = 17;
  localparam int unsigned SLOT_OP15 = 19;
  localparam int unsigned SLOT_SUB  = 23;

  localparam logic [15:0] IMM_MASK_DEFAULT = 16'h9000;

  typedef enum logic [1:0] {S_OP, S_IMM, S_OUT} state_e;

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave is the stage's view, master is the view of whatever drives and consumes it.
interface instr_decode_stage_if #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned IMM_WORDS = 1
);
  import decode_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [WORD_W-1:0]             in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [NDEC-1:0]               out_onehot;
  logic [WORD_W-5:0]             out_operand;
  logic [IMM_WORDS*WORD_W-1:0]   out_imm;
  logic                          out_has_imm;
  logic                          out_illegal;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_onehot, out_operand, out_imm, out_has_imm, out_illegal
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_onehot, out_operand, out_imm, out_has_imm, out_illegal
  );

endinterface

// File: rtl/decode_map.sv
// Combinational opcode/subfield to one-hot control map.
// Illegal-encoding detection is compiled in only when DECODE_ILLEGAL_EN is defined.
module decode_map
  import decode_pkg::*;
(
  input  logic [3:0]      op_i,
  input  logic [3:0]      sub_i,
  output logic [NDEC-1:0] onehot_o,
  output logic            illegal_o
);

  logic [4:0] slot;

  always_comb begin
    slot = 5'(SLOT_OP0);
    unique case (op_i) inside
      4'd0:          slot = 5'(SLOT_OP0);
      4'd1:          slot = 5'(SLOT_OP1) + {3'b000, sub_i[1:0]};
      [4'd2:4'd11]:  slot = 5'(SLOT_ALU) + {1'b0, op_i} - 5'd2;
      4'd12:         slot = 5'(SLOT_OP12) + {4'b0000, sub_i[0]};
      4'd13, 4'd14:  slot = 5'(SLOT_OP13) + {1'b0, op_i} - 5'd13;
      default:       slot = 5'(SLOT_OP15) + {3'b000, sub_i[1:0]};
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  assign illegal_o = (((op_i == 4'd1) || (op_i == 4'd15)) && (sub_i[3:2] != 2'b00)) ||
                     ((op_i == 4'd12) && (sub_i[3:1] != 3'b000));
`else
  assign illegal_o = 1'b0;
`endif

  // Subfield is always exported raw in the top bits, even for illegal words.
  always_comb begin
    onehot_o = '0;
    if (!illegal_o) onehot_o[slot] = 1'b1;
    onehot_o[SLOT_SUB +: 4] = sub_i;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered, handshaked decode stage: decodes an opcode word, optionally collects
// IMM_WORDS immediate words, then holds the result until execute takes it.
// Optional feature macro: DECODE_ILLEGAL_EN.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned IMM_WORDS = 1,
  parameter logic [15:0] IMM_MASK  = IMM_MASK_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  instr_decode_stage_if.slave bus
);

  localparam int unsigned ImmW = IMM_WORDS * WORD_W;
  localparam int unsigned CntW = $clog2(IMM_WORDS + 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              valid_q;
  logic [NDEC-1:0]   onehot_q;
  logic [WORD_W-5:0] operand_q;
  logic [ImmW-1:0]   imm_q;
  logic              has_imm_q;
  logic              illegal_q;

  logic [NDEC-1:0]   map_onehot;
  logic              map_illegal;
  logic              load;
  logic              go_imm;

  decode_map u_decode_map (
    .op_i      (bus.in_data[WORD_W-1 -: 4]),
    .sub_i     (bus.in_data[3:0]),
    .onehot_o  (map_onehot),
    .illegal_o (map_illegal)
  );

  // A new opcode word is taken when idle, or when the held result retires the same cycle.
  assign load   = bus.in_valid && ((state_q == S_OP) || ((state_q == S_OUT) && bus.out_ready));
  assign go_imm = IMM_MASK[bus.in_data[WORD_W-1 -: 4]] && !map_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OP;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      onehot_q  <= '0;
      operand_q <= '0;
      imm_q     <= '0;
      has_imm_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load) begin
      onehot_q  <= map_onehot;
      operand_q <= bus.in_data[WORD_W-5:0];
      illegal_q <= map_illegal;
      imm_q     <= '0;
      has_imm_q <= 1'b0;
      cnt_q     <= '0;
      if (go_imm) begin
        state_q <= S_IMM;
        valid_q <= 1'b0;
      end else begin
        state_q <= S_OUT;
        valid_q <= 1'b1;
      end
    end else if ((state_q == S_IMM) && bus.in_valid) begin
      imm_q <= (imm_q << WORD_W) | ImmW'(bus.in_data);
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CntW'(IMM_WORDS - 1)) begin
        has_imm_q <= 1'b1;
        state_q   <= S_OUT;
        valid_q   <= 1'b1;
      end
    end else if ((state_q == S_OUT) && bus.out_ready) begin
      state_q <= S_OP;
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = (state_q != S_OUT) || bus.out_ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_onehot  = onehot_q;
  assign bus.out_operand = operand_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_has_imm = has_imm_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage with WORD_W=8, IMM_WORDS=1, default IMM_MASK.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  instr_decode_stage_if #(.WORD_W(8), .IMM_WORDS(1)) bus ();

  instr_decode_stage #(.WORD_W(8), .IMM_WORDS(1), .IMM_MASK(16'h9000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
    vecs++; if (bus.out_onehot !== 27'd0) begin errs++; $display("FAIL rst_onehot got %h want 0", bus.out_onehot); end
    vecs++; if ({bus.out_imm, bus.out_has_imm, bus.out_illegal, bus.out_operand} !== 14'd0) begin
      errs++; $display("FAIL rst_fields got %h/%b/%b/%h want 0", bus.out_imm, bus.out_has_imm, bus.out_illegal, bus.out_operand); end
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1; bus.in_data = 8'h25; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    vecs++; if (bus.out_onehot !== ((27'd1 << 5) | (27'd5 << 23))) begin
      errs++; $display("FAIL single_onehot got %h want %h", bus.out_onehot, (27'd1 << 5) | (27'd5 << 23)); end
    vecs++; if (bus.out_has_imm !== 1'b0 || bus.out_imm !== 8'h00) begin
      errs++; $display("FAIL single_imm got %b/%h want 0/00", bus.out_has_imm, bus.out_imm); end
    vecs++; if (bus.out_operand !== 4'h5) begin errs++; $display("FAIL single_operand got %h want 5", bus.out_operand); end
    step();
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL single_retire got %b want 0", bus.out_valid); end
  endtask

  task automatic test_imm();
    bus.in_valid = 1'b1; bus.in_data = 8'hC1; bus.out_ready = 1'b1;
    step();
    vecs++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL imm_wait got valid=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
    bus.in_data = 8'hA7;
    step();
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL imm_valid got %b want 1", bus.out_valid); end
    vecs++; if (bus.out_onehot !== ((27'd1 << 16) | (27'd1 << 23))) begin
      errs++; $display("FAIL imm_onehot got %h want %h", bus.out_onehot, (27'd1 << 16) | (27'd1 << 23)); end
    vecs++; if (bus.out_imm !== 8'hA7 || bus.out_has_imm !== 1'b1) begin
      errs++; $display("FAIL imm_value got %h/%b want a7/1", bus.out_imm, bus.out_has_imm); end
    step();
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL imm_retire got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3];
    logic [26:0] exp   [3];
    words[0] = 8'h00; exp[0] = 27'd1;
    words[1] = 8'h13; exp[1] = (27'd1 << 4) | (27'd3 << 23);
    words[2] = 8'h2F; exp[2] = (27'd1 << 5) | (27'd15 << 23);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = words[i];
      vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, bus.in_ready); end
      step();
      vecs++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== exp[i]) begin
        errs++; $display("FAIL b2b_out[%0d] got %b/%h want 1/%h", i, bus.out_valid, bus.out_onehot, exp[i]); end
    end
    bus.in_valid = 1'b0;
    step();
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    logic [26:0] exp_oh;
    exp_oh = (27'd1 << 21) | (27'd2 << 23);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hF2;
    step();
    bus.in_data = 8'h5A;
    step();
    bus.in_data = 8'h33;
    for (int i = 0; i < 5; i++) begin
      vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, bus.in_ready); end
      vecs++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== exp_oh || bus.out_imm !== 8'h5A ||
                  bus.out_has_imm !== 1'b1) begin
        errs++; $display("FAIL stall_hold[%0d] got %b/%h/%h/%b want 1/%h/5a/1", i, bus.out_valid,
                         bus.out_onehot, bus.out_imm, bus.out_has_imm, exp_oh); end
      step();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL stall_release_rdy got %b want 1", bus.in_ready); end
    step();
    vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL stall_handshake got %b want 0", bus.out_valid); end
    step();
    vecs++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++; $display("FAIL stall_idle got %b/%b want 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_mid_imm();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hF0;
    step();
    bus.in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if ({bus.out_valid, bus.out_onehot, bus.out_imm, bus.out_has_imm, bus.out_illegal} !== 38'd0) begin
      errs++; $display("FAIL midrst_zero got %b/%h/%h/%b/%b want 0", bus.out_valid, bus.out_onehot,
                       bus.out_imm, bus.out_has_imm, bus.out_illegal); end
    bus.in_valid = 1'b1; bus.in_data = 8'h30;
    step();
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== (27'd1 << 6) || bus.out_has_imm !== 1'b0) begin
      errs++; $display("FAIL midrst_next got %b/%h/%b want 1/%h/0", bus.out_valid, bus.out_onehot,
                       bus.out_has_imm, 27'd1 << 6); end
    step();
  endtask

  task automatic test_illegal();
    logic [26:0] exp_oh;
    logic        exp_ill;
`ifdef DECODE_ILLEGAL_EN
    exp_oh = 27'd12 << 23; exp_ill = 1'b1;
`else
    exp_oh = (27'd1 << 1) | (27'd12 << 23); exp_ill = 1'b0;
`endif
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h1C;
    step();
    bus.in_valid = 1'b0;
    vecs++; if (bus.out_valid !== 1'b1 || bus.out_onehot !== exp_oh || bus.out_illegal !== exp_ill) begin
      errs++; $display("FAIL illegal_1c got %b/%h/%b want 1/%h/%b", bus.out_valid, bus.out_onehot,
                       bus.out_illegal, exp_oh, exp_ill); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_imm();
    test_back_to_back();
    test_stall();
    test_reset_mid_imm();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
